// File: rtl/ifu_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_if
// Groups every handshake and bus signal of the instruction fetch unit so the
// IFU and its environment (memory model, decode stage, next-PC selector) can
// be connected with one port.
//
// Signal summary (direction as seen from the IFU, modport master):
//   pc_in_valid   in   1   downstream presents next PC
//   pc_in         in   32  next PC (bit0 already cleared by producer)
//   pc_in_ready   out  1   IFU accepts next PC
//   mem_req_valid out  1   read request valid
//   mem_req_addr  out  32  read address = current fetch PC
//   mem_req_ready in   1   memory accepts request
//   mem_rsp_valid in   1   read data valid
//   mem_rsp_data  in   32  instruction word
//   mem_rsp_err   in   1   bus error, qualified by mem_rsp_valid
//   inst_valid    out  1   inst/inst_pc valid to decode
//   inst          out  32  fetched instruction
//   inst_pc       out  32  PC of inst
//   inst_ready    in   1   decode consumes inst
//   fetch_err     out  1   sticky fault
//
// Modports: master = IFU side, slave = environment side.
// ---------------------------------------------------------------------------
interface ifu_fetch_if;
  logic        pc_in_valid;
  logic [31:0] pc_in;
  logic        pc_in_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_err;

  modport master (
    input  pc_in_valid, pc_in, mem_req_ready, mem_rsp_valid,
           mem_rsp_data, mem_rsp_err, inst_ready,
    output pc_in_ready, mem_req_valid, mem_req_addr, inst_valid,
           inst, inst_pc, fetch_err
  );

  modport slave (
    output pc_in_valid, pc_in, mem_req_ready, mem_rsp_valid,
           mem_rsp_data, mem_rsp_err, inst_ready,
    input  pc_in_ready, mem_req_valid, mem_req_addr, inst_valid,
           inst, inst_pc, fetch_err
  );
endinterface

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit feeding the decode/execute datapath. Holds the
// fetch PC, issues one 32-bit read per instruction over a valid/ready
// request channel, buffers the returned word and presents it with its PC to
// decode. The next PC (selected downstream) comes back over its own
// handshake. Strictly one instruction in flight, no prefetch.
//
// Loop: REQ -> WAIT -> OUT -> NEXT -> REQ. ERR is terminal until rst.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//   TIMEOUT_CYCLES  max WAIT cycles without a response before fault,
//                   0 disables the timeout
//
// Ports:
//   clk  in  clock
//   rst  in  synchronous, active-high reset
//   ifu  ifu_fetch_if.master  next-PC, memory and decode handshakes
//
// Build option:
//   IFU_MISALIGN_CHECK_EN  when defined, a next PC with pc_in[1:0] != 0 (or a
//   misaligned RESET_PC) sends the unit to ERR instead of issuing a fetch.
//   When undefined, the PC is passed to mem_req_addr unchanged.
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master ifu
);

  // Timeout counter is wide enough to hold TIMEOUT_CYCLES, never narrower
  // than one bit so the disabled case still elaborates cleanly.
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  localparam logic [2:0] ST_REQ  = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_OUT  = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic MISALIGN_CHECK = 1'b1;
`else
  localparam logic MISALIGN_CHECK = 1'b0;
`endif

  // A misaligned reset vector can only be reported by starting in ERR.
  localparam logic [2:0] ST_RESET =
    (MISALIGN_CHECK && (RESET_PC[1:0] != 2'b00)) ? ST_ERR : ST_REQ;

  logic [2:0]       state_q,   state_d;
  logic [31:0]      fetchPc_q, fetchPc_d;
  logic [31:0]      inst_q,    inst_d;
  logic [31:0]      instPc_q,  instPc_d;
  logic [TMO_W-1:0] tmoCnt_q,  tmoCnt_d;

  logic pcMisaligned;
  logic tmoExpired;

  assign pcMisaligned = MISALIGN_CHECK && (ifu.pc_in[1:0] != 2'b00);
  assign tmoExpired   = (TIMEOUT_CYCLES != 0) && (tmoCnt_q == TMO_LAST);

  // Next-state and datapath update. A response always takes priority over
  // timeout expiry in the same cycle; responses and next-PC offers outside
  // their own state fall through the default hold.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    inst_d    = inst_q;
    instPc_d  = instPc_q;
    tmoCnt_d  = tmoCnt_q;
    case (state_q)
      ST_REQ: begin
        if (ifu.mem_req_ready) begin
          state_d  = ST_WAIT;
          tmoCnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (ifu.mem_rsp_valid) begin
          if (ifu.mem_rsp_err) begin
            state_d = ST_ERR;
          end else begin
            inst_d   = ifu.mem_rsp_data;
            instPc_d = fetchPc_q;
            state_d  = ST_OUT;
          end
        end else if (tmoExpired) begin
          state_d = ST_ERR;
        end else if (tmoCnt_q != TMO_MAX) begin
          tmoCnt_d = tmoCnt_q + TMO_ONE;
        end
      end
      ST_OUT: begin
        if (ifu.inst_ready) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (ifu.pc_in_valid) begin
          if (pcMisaligned) begin
            state_d = ST_ERR;
          end else begin
            fetchPc_d = ifu.pc_in;
            state_d   = ST_REQ;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  // State registers; rst restores everything and abandons any fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      fetchPc_q <= RESET_PC;
      inst_q    <= '0;
      instPc_q  <= '0;
      tmoCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      inst_q    <= inst_d;
      instPc_q  <= instPc_d;
      tmoCnt_q  <= tmoCnt_d;
    end
  end

  // Handshake outputs are pure state decodes, so ERR forces every valid and
  // ready low and fetch_err stays set until reset.
  assign ifu.mem_req_valid = (state_q == ST_REQ);
  assign ifu.mem_req_addr  = fetchPc_q;
  assign ifu.inst_valid    = (state_q == ST_OUT);
  assign ifu.inst          = inst_q;
  assign ifu.inst_pc       = instPc_q;
  assign ifu.pc_in_ready   = (state_q == ST_NEXT);
  assign ifu.fetch_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
// Directed bench for ifu_fetch built with TIMEOUT_CYCLES=4. Inputs change #1
// after a rising edge and outputs are sampled at that same point, so every
// check sees the state that the preceding edge produced.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  ifu_fetch_if bus ();

  ifu_fetch #(
    .RESET_PC       (32'h8000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ifu (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive every environment-side input at once.
  task automatic applyStimulus(input logic reqRdy, input logic rspVld,
                               input logic [31:0] rspData, input logic rspErr,
                               input logic instRdy, input logic pcVld,
                               input logic [31:0] pcIn);
    bus.mem_req_ready = reqRdy;
    bus.mem_rsp_valid = rspVld;
    bus.mem_rsp_data  = rspData;
    bus.mem_rsp_err   = rspErr;
    bus.inst_ready    = instRdy;
    bus.pc_in_valid   = pcVld;
    bus.pc_in         = pcIn;
  endtask

  task automatic stepCycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    stepCycle(3);
    rst = 1'b0;
  endtask

  // Main sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    idle();
    stepCycle(3);

    // Reset values
    checkOutput("rst_req_valid", bus.mem_req_valid, 1);
    checkOutput("rst_addr", bus.mem_req_addr, 32'h8000_0000);
    checkOutput("rst_inst_valid", bus.inst_valid, 0);
    checkOutput("rst_pc_in_ready", bus.pc_in_ready, 0);
    checkOutput("rst_fetch_err", bus.fetch_err, 0);
    checkOutput("rst_inst", bus.inst, 32'h0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);
    rst = 1'b0;

    // Zero-wait fetch of reset vector, then redirect to +4
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_req_valid", bus.mem_req_valid, 1);
    stepCycle(1);
    checkOutput("t1_wait_req_valid", bus.mem_req_valid, 0);
    checkOutput("t1_wait_inst_valid", bus.inst_valid, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0413, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    checkOutput("t1_inst_valid", bus.inst_valid, 1);
    checkOutput("t1_inst", bus.inst, 32'h0000_0413);
    checkOutput("t1_inst_pc", bus.inst_pc, 32'h8000_0000);
    checkOutput("t1_out_pc_in_ready", bus.pc_in_ready, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    stepCycle(1);
    checkOutput("t1_next_inst_valid", bus.inst_valid, 0);
    checkOutput("t1_next_pc_in_ready", bus.pc_in_ready, 1);
    checkOutput("t1_next_req_valid", bus.mem_req_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0004);
    stepCycle(1);
    checkOutput("t1_req2_valid", bus.mem_req_valid, 1);
    checkOutput("t1_req2_addr", bus.mem_req_addr, 32'h8000_0004);
    checkOutput("t1_req2_pc_in_ready", bus.pc_in_ready, 0);

    // Request stalled 5 cycles, response two WAIT cycles later
    idle();
    for (int i = 0; i < 5; i++) begin
      stepCycle(1);
      checkOutput("t2_stall_valid", bus.mem_req_valid, 1);
      checkOutput("t2_stall_addr", bus.mem_req_addr, 32'h8000_0004);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    idle();
    stepCycle(2);
    checkOutput("t2_wait_inst_valid", bus.inst_valid, 0);
    checkOutput("t2_wait_req_valid", bus.mem_req_valid, 0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_inst_valid", bus.inst_valid, 1);
    checkOutput("t2_inst", bus.inst, 32'hDEAD_BEEF);
    checkOutput("t2_inst_pc", bus.inst_pc, 32'h8000_0004);
    stepCycle(1);
    checkOutput("t2_single_pulse", bus.inst_valid, 0);
    checkOutput("t2_pc_in_ready", bus.pc_in_ready, 1);

    // Decode back-pressure; stray response and next-PC offers ignored
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0008);
    stepCycle(1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    applyStimulus(1'b0, 1'b1, 32'h0010_0073, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_1234);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_hold_valid", bus.inst_valid, 1);
      checkOutput("t3_hold_inst", bus.inst, 32'h0010_0073);
      checkOutput("t3_hold_inst_pc", bus.inst_pc, 32'h8000_0008);
      checkOutput("t3_hold_pc_in_ready", bus.pc_in_ready, 0);
      checkOutput("t3_hold_no_req", bus.mem_req_valid, 0);
      stepCycle(1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    stepCycle(1);
    idle();
    stepCycle(1);
    checkOutput("t3_next_wait_ready", bus.pc_in_ready, 1);
    checkOutput("t3_next_wait_no_req", bus.mem_req_valid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_000C);
    stepCycle(1);
    checkOutput("t3_req_addr", bus.mem_req_addr, 32'h8000_000C);

    // Timeout after 4 silent WAIT cycles; later response ignored
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    idle();
    stepCycle(3);
    checkOutput("t4_not_yet_err", bus.fetch_err, 0);
    stepCycle(1);
    checkOutput("t4_timeout_err", bus.fetch_err, 1);
    checkOutput("t4_err_req_valid", bus.mem_req_valid, 0);
    checkOutput("t4_err_pc_in_ready", bus.pc_in_ready, 0);
    applyStimulus(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
    stepCycle(2);
    checkOutput("t4_late_rsp_err", bus.fetch_err, 1);
    checkOutput("t4_late_rsp_valid", bus.inst_valid, 0);
    checkOutput("t4_late_rsp_inst", bus.inst, 32'h0010_0073);
    doReset();
    checkOutput("t4_rst_err", bus.fetch_err, 0);
    checkOutput("t4_rst_addr", bus.mem_req_addr, 32'h8000_0000);
    checkOutput("t4_rst_inst", bus.inst, 32'h0);

    // Response on the cycle the timeout would expire wins
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    idle();
    stepCycle(3);
    applyStimulus(1'b0, 1'b1, 32'h0000_0093, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    checkOutput("t4_edge_err", bus.fetch_err, 0);
    checkOutput("t4_edge_valid", bus.inst_valid, 1);
    checkOutput("t4_edge_inst", bus.inst, 32'h0000_0093);

    // Bus error response
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    stepCycle(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0010);
    stepCycle(1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    applyStimulus(1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle(1);
    checkOutput("t5_err", bus.fetch_err, 1);
    checkOutput("t5_no_inst_valid", bus.inst_valid, 0);
    stepCycle(2);
    checkOutput("t5_err_sticky", bus.fetch_err, 1);
    checkOutput("t5_still_no_inst", bus.inst_valid, 0);

    // Reset while waiting: counter and fetch restart from scratch
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    idle();
    stepCycle(2);
    rst = 1'b1;
    stepCycle(1);
    rst = 1'b0;
    checkOutput("t5_midwait_req", bus.mem_req_valid, 1);
    checkOutput("t5_midwait_addr", bus.mem_req_addr, 32'h8000_0000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle(1);
    idle();
    stepCycle(3);
    checkOutput("t5_tmo_restart", bus.fetch_err, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0513, 1'b0, 1'b1, 1'b0, 32'h0);
    stepCycle(1);
    checkOutput("t5_refetch_inst", bus.inst, 32'h0000_0513);

    // Misaligned next PC
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    stepCycle(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0002);
    stepCycle(1);
    idle();
`ifdef IFU_MISALIGN_CHECK_EN
    checkOutput("t6_misalign_err", bus.fetch_err, 1);
    checkOutput("t6_misalign_no_req", bus.mem_req_valid, 0);
`else
    checkOutput("t6_misalign_req", bus.mem_req_valid, 1);
    checkOutput("t6_misalign_addr", bus.mem_req_addr, 32'h8000_0002);
    checkOutput("t6_misalign_no_err", bus.fetch_err, 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
